// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, issues one-at-a-time word fetches, drives the IF/ID pc/instr pair.
// Latency: response to if_valid is 1 cycle when unstalled; a response that lands during a stall waits in a one-entry buffer.
// Backpressure: stall holds if_* outputs; a full buffer blocks new requests; redirect flushes everything. Optional FETCH_STATS_EN adds perf counters.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req_valid,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_req_ready,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_instr,
    output logic        o_if_valid
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] o_perf_fetched,
    output logic [31:0] o_perf_killed
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_KILL = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_req_pc;
    logic        r_buf_valid;
    logic [31:0] r_buf_pc;
    logic [31:0] r_buf_instr;

    logic        w_req_fire;
    logic        w_rsp_take;
    logic        w_rsp_drop;
    logic        w_if_load;
    logic [31:0] w_redirect_target;

    // Requests only go out when the buffer has room, so a response never finds it full.
    assign o_imem_req_valid  = (r_state == S_REQ) && !r_buf_valid && !i_reset;
    assign o_imem_req_addr   = r_pc;
    assign w_req_fire        = o_imem_req_valid && i_imem_req_ready;
    // A response in S_WAIT is kept unless a redirect lands in the same cycle.
    assign w_rsp_take        = (r_state == S_WAIT) && i_imem_rsp_valid && !i_redirect_valid;
    assign w_rsp_drop        = i_imem_rsp_valid &&
                               ((r_state == S_KILL) || ((r_state == S_WAIT) && i_redirect_valid));
    assign w_if_load         = !i_redirect_valid && !i_stall && (r_buf_valid || w_rsp_take);
    // Targets are word aligned; the low two bits of the redirect address are ignored.
    assign w_redirect_target = i_redirect_pc & 32'hFFFF_FFFC;

    // Fetch FSM: tracks the single outstanding request and whether its data is wanted.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state  <= S_REQ;
            r_req_pc <= 32'd0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_req_fire) begin
                        r_req_pc <= r_pc;
                        r_state  <= i_redirect_valid ? S_KILL : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_imem_rsp_valid) begin
                        r_state <= S_REQ;
                    end else if (i_redirect_valid) begin
                        r_state <= S_KILL;
                    end
                end
                S_KILL: begin
                    if (i_imem_rsp_valid) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

    // Next-fetch PC: redirect wins over the sequential increment.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_pc <= RESET_PC;
        end else if (i_redirect_valid) begin
            r_pc <= w_redirect_target;
        end else if (w_req_fire) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    // IF/ID output register and hold buffer, in priority redirect > stall > buffer > response > bubble.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_if_pc     <= 32'd0;
            o_if_instr  <= NOP_INSTR;
            o_if_valid  <= 1'b0;
            r_buf_valid <= 1'b0;
            r_buf_pc    <= 32'd0;
            r_buf_instr <= 32'd0;
        end else if (i_redirect_valid) begin
            o_if_instr  <= NOP_INSTR;
            o_if_valid  <= 1'b0;
            r_buf_valid <= 1'b0;
        end else if (i_stall) begin
            if (w_rsp_take) begin
                r_buf_pc    <= r_req_pc;
                r_buf_instr <= i_imem_rsp_data;
                r_buf_valid <= 1'b1;
            end
        end else if (r_buf_valid) begin
            o_if_pc     <= r_buf_pc;
            o_if_instr  <= r_buf_instr;
            o_if_valid  <= 1'b1;
            r_buf_valid <= 1'b0;
        end else if (w_rsp_take) begin
            o_if_pc    <= r_req_pc;
            o_if_instr <= i_imem_rsp_data;
            o_if_valid <= 1'b1;
        end else begin
            o_if_instr <= NOP_INSTR;
            o_if_valid <= 1'b0;
        end
    end

`ifdef FETCH_STATS_EN
    // Free-running counters of delivered and discarded fetches; wrap naturally.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_perf_fetched <= 32'd0;
            o_perf_killed  <= 32'd0;
        end else begin
            if (w_if_load) begin
                o_perf_fetched <= o_perf_fetched + 32'd1;
            end
            if (w_rsp_drop) begin
                o_perf_killed <= o_perf_killed + 32'd1;
            end
        end
    end
`else
    // Without counters the drop indication has no consumer.
    logic w_unused_drop;
    assign w_unused_drop = w_rsp_drop;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed fetch/stall/redirect sequences, then randomized traffic.
// Instruction memory is modelled with a random response latency; outputs are checked each cycle.
// Expected stream: program-order PCs from the last redirect target, each delivered exactly once.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        stall = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] rpc   = 32'd0;
    logic        ready = 1'b1;
    logic        rsp_v = 1'b0;
    logic [31:0] rsp_d = 32'd0;
    logic        req_v;
    logic [31:0] req_a;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_v;
`ifdef FETCH_STATS_EN
    logic [31:0] perf_f;
    logic [31:0] perf_k;
`endif

    if_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .i_clock          (clk),
        .i_reset          (rst),
        .i_stall          (stall),
        .i_redirect_valid (redir),
        .i_redirect_pc    (rpc),
        .o_imem_req_valid (req_v),
        .o_imem_req_addr  (req_a),
        .i_imem_req_ready (ready),
        .i_imem_rsp_valid (rsp_v),
        .i_imem_rsp_data  (rsp_d),
        .o_if_pc          (if_pc),
        .o_if_instr       (if_instr),
        .o_if_valid       (if_v)
`ifdef FETCH_STATS_EN
        ,
        .o_perf_fetched   (perf_f),
        .o_perf_killed    (perf_k)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Memory model state: at most one request in flight.
    bit          mem_busy = 0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr = 32'd0;
    bit          mem_kill = 0;
    int          lat_min  = 1;
    int          lat_max  = 1;

    // Reference stream state.
    logic [31:0] exp_req, exp_out;
    logic [31:0] prev_pc, prev_instr;
    logic        prev_v;
    logic [31:0] exp_fetched, exp_killed;
    logic [31:0] acc_last, acc_prev;
    logic [15:0] vhist;
    int          delivered = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1F0F};
    endfunction

    task automatic model_init();
        exp_req     = RESET_PC;
        exp_out     = RESET_PC;
        prev_pc     = 32'd0;
        prev_instr  = NOP_INSTR;
        prev_v      = 1'b0;
        exp_fetched = 32'd0;
        exp_killed  = 32'd0;
        acc_last    = 32'd0;
        acc_prev    = 32'd0;
        vhist       = 16'd0;
        mem_busy    = 0;
        mem_kill    = 0;
        mem_cnt     = 0;
    endtask

    // Asynchronous reset asserted between clock edges; outputs must react immediately.
    task automatic do_reset();
        @(negedge clk);
        stall = 0; redir = 0; rsp_v = 0;
        #2 rst = 1'b1;
        #1;
        chk("rst_if_valid", {31'd0, if_v}, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_instr", if_instr, NOP_INSTR);
        chk("rst_req_valid", {31'd0, req_v}, 32'd0);
`ifdef FETCH_STATS_EN
        chk("rst_perf_fetched", perf_f, 32'd0);
        chk("rst_perf_killed", perf_k, 32'd0);
`endif
        model_init();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock cycle: drive inputs after the falling edge, check outputs at the next falling edge.
    task automatic step(input bit st, input bit rd, input logic [31:0] tgt);
        bit          s_acc;
        logic [31:0] s_addr;
        bit          s_rsp;
        stall = st;
        redir = rd;
        rpc   = tgt;
        rsp_v = 1'b0;
        rsp_d = $urandom;
        if (mem_busy && mem_cnt == 0) begin
            rsp_v = 1'b1;
            rsp_d = mem_word(mem_addr);
        end
        s_rsp = rsp_v;
        #1;
        s_acc  = req_v && ready;
        s_addr = req_a;
        if (mem_busy) chk("one_outstanding", {31'd0, req_v}, 32'd0);
        if (s_acc) begin
            chk("req_addr", s_addr, exp_req);
            acc_prev = acc_last;
            acc_last = s_addr;
        end
        @(posedge clk);
        if (s_rsp) begin
            if (mem_kill || rd) exp_killed = exp_killed + 32'd1;
            mem_busy = 0;
        end else if (mem_busy) begin
            mem_cnt--;
            if (rd) mem_kill = 1;
        end
        if (s_acc) begin
            mem_busy = 1;
            mem_addr = s_addr;
            mem_cnt  = $urandom_range(lat_max, lat_min) - 1;
            mem_kill = rd;
        end
        if (rd) exp_req = tgt & 32'hFFFF_FFFC;
        else if (s_acc) exp_req = exp_req + 32'd4;
        @(negedge clk);
        if (rd) begin
            chk("redir_if_valid", {31'd0, if_v}, 32'd0);
            chk("redir_if_pc", if_pc, prev_pc);
            chk("redir_if_instr", if_instr, NOP_INSTR);
            exp_out = tgt & 32'hFFFF_FFFC;
        end else if (st) begin
            chk("stall_if_valid", {31'd0, if_v}, {31'd0, prev_v});
            chk("stall_if_pc", if_pc, prev_pc);
            chk("stall_if_instr", if_instr, prev_instr);
        end else if (if_v) begin
            chk("deliver_pc", if_pc, exp_out);
            chk("deliver_instr", if_instr, mem_word(exp_out));
            exp_out     = exp_out + 32'd4;
            exp_fetched = exp_fetched + 32'd1;
            delivered++;
        end else begin
            chk("bubble_if_pc", if_pc, prev_pc);
            chk("bubble_if_instr", if_instr, NOP_INSTR);
        end
`ifdef FETCH_STATS_EN
        chk("perf_fetched", perf_f, exp_fetched);
        chk("perf_killed", perf_k, exp_killed);
`endif
        prev_pc    = if_pc;
        prev_instr = if_instr;
        prev_v     = if_v;
        vhist      = {vhist[14:0], if_v};
    endtask

    task automatic rand_steps(input int n);
        logic [31:0] tgt;
        for (int i = 0; i < n; i++) begin
            ready   = ($urandom_range(0, 9) < 7);
            lat_min = 1;
            lat_max = 3;
            if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 + $urandom_range(0, 15);
            else tgt = $urandom;
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0), tgt);
        end
    endtask

    initial begin
        model_init();
        do_reset();
        ready = 1'b1;
        // Straight-line fetch: valid alternates with bubbles.
        for (int i = 0; i < 4; i++) step(0, 0, 32'd0);
        chk("fetch_pattern", {28'd0, vhist[3:0]}, 32'h5);
        // Response for pc=8 arrives under stall and is held.
        step(0, 0, 32'd0);
        step(1, 0, 32'd0);
        chk("stall_blocks_req0", {31'd0, req_v}, 32'd0);
        step(1, 0, 32'd0);
        chk("stall_blocks_req1", {31'd0, req_v}, 32'd0);
        step(1, 0, 32'd0);
        chk("buf_blocks_req", {31'd0, req_v}, 32'd0);
        step(0, 0, 32'd0);
        chk("buf_drain_valid", {31'd0, if_v}, 32'd1);
        chk("buf_drain_pc", if_pc, 32'd8);
        // Redirect while waiting on memory.
        lat_min = 2; lat_max = 2;
        step(0, 0, 32'd0);
        chk("no_dup_after_drain", {31'd0, if_v}, 32'd0);
        step(0, 1, 32'h100);
        chk("wait_redir_bubble", {31'd0, if_v}, 32'd0);
        lat_min = 1; lat_max = 1;
        step(0, 0, 32'd0);
`ifdef FETCH_STATS_EN
        chk("perf_killed_one", perf_k, 32'd1);
`endif
        chk("redir_req_valid", {31'd0, req_v}, 32'd1);
        chk("redir_req_addr", req_a, 32'h100);
        // Redirect under stall with the buffer full, to a misaligned target.
        step(0, 0, 32'd0);
        step(1, 0, 32'd0);
        step(1, 1, 32'h203);
        chk("flush_bubble", {31'd0, if_v}, 32'd0);
        chk("flush_req_valid", {31'd0, req_v}, 32'd1);
        chk("flush_req_addr", req_a, 32'h200);
        // PC wraps from the top of the address space.
        step(0, 0, 32'd0);
        step(0, 1, 32'hFFFF_FFFC);
        for (int i = 0; i < 4; i++) step(0, 0, 32'd0);
        chk("wrap_prev_addr", acc_prev, 32'hFFFF_FFFC);
        chk("wrap_next_addr", acc_last, 32'h0000_0000);
        // Random traffic, a mid-run asynchronous reset, then more traffic.
        rand_steps(3000);
        do_reset();
        rand_steps(1000);
        chk("progress", (delivered > 200) ? 32'd1 : 32'd0, 32'd1);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
